// File: rtl/npu_seq_ctrl.sv
// Wishbone-programmed job sequencer for the edu_tpu array: weight load, activation stream, result write-back.
// Build option: define NPU_SEQ_CYCLE_CNT_EN to implement the CYCLES busy-cycle counter (reads 0 otherwise).
module npu_seq_ctrl #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int N  = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [31:0]   wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    output logic          wb_ack_o,
    output logic [31:0]   wb_dat_o,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic          arr_load_w_o,
    output logic          arr_valid_o,
    output logic [DW-1:0] arr_data_o,
    input  logic          arr_res_valid_i,
    input  logic [DW-1:0] arr_res_i,
    output logic          irq_o
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LOAD_W = 3'd1, S_STREAM = 3'd2, S_DRAIN = 3'd3, S_DONE = 3'd4
    } state_t;

    localparam logic [8:0] N_W = 9'(N);

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] cfg_q, cfg_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic [8:0]  idx_q, idx_d;
    logic [7:0]  res_cnt_q, res_cnt_d;
    logic        pend_w_q, pend_w_d;
    logic        pend_x_q, pend_x_d;
    logic [31:0] cycles_rd;

    logic       wb_req, wb_wr, busy, start_cmd, abort_cmd;
    logic [1:0] reg_sel;
    logic [7:0] w_base, x_base, y_base, x_len;
    logic       rd_w, rd_x, res_wr, last_x;
    logic       unused_adr_bits;

    assign unused_adr_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

    assign w_base = cfg_q[7:0];
    assign x_base = cfg_q[15:8];
    assign y_base = cfg_q[23:16];
    assign x_len  = cfg_q[31:24];

    assign wb_req    = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wb_wr     = wb_req & wb_we_i & (wb_sel_i == 4'hF);
    assign reg_sel   = wb_adr_i[3:2];
    assign busy      = (state_q != S_IDLE);
    // Abort beats start when both bits arrive in the same CTRL write.
    assign start_cmd = wb_wr & (reg_sel == 2'd0) & wb_dat_i[0] & ~wb_dat_i[2] & ~busy;
    assign abort_cmd = wb_wr & (reg_sel == 2'd0) & wb_dat_i[2] & busy;

    // Result writes own the port; a STREAM read simply waits a cycle behind them.
    assign res_wr = arr_res_valid_i & ((state_q == S_STREAM) | (state_q == S_DRAIN));
    assign rd_w   = (state_q == S_LOAD_W) & (idx_q < N_W);
    assign rd_x   = (state_q == S_STREAM) & ~arr_res_valid_i;
    assign last_x = rd_x & ((idx_q + 9'd1) == {1'b0, x_len});

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_cmd) state_d = S_LOAD_W;
            S_LOAD_W: if (idx_q == N_W) state_d = (x_len != 8'd0) ? S_STREAM : S_DONE;
            S_STREAM: if (last_x) state_d = S_DRAIN;
            S_DRAIN:  if (res_cnt_q == x_len) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort_cmd) state_d = S_IDLE;
    end

    always_comb begin
        ram_en_o     = rd_w | rd_x | res_wr;
        ram_we_o     = res_wr;
        ram_wdata_o  = res_wr ? arr_res_i : '0;
        ram_addr_o   = '0;
        if (res_wr)    ram_addr_o = AW'(y_base) + AW'(res_cnt_q);
        else if (rd_w) ram_addr_o = AW'(w_base) + AW'(idx_q);
        else if (rd_x) ram_addr_o = AW'(x_base) + AW'(idx_q);
        arr_load_w_o = pend_w_q;
        arr_valid_o  = pend_x_q;
        arr_data_o   = (pend_w_q | pend_x_q) ? ram_rdata_i : '0;
        irq_o        = done_q & irq_en_q;
        wb_ack_o     = ack_q;
        wb_dat_o     = dat_q;
    end

    always_comb begin
        ack_d     = wb_req;
        dat_d     = '0;
        irq_en_d  = irq_en_q;
        cfg_d     = cfg_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        idx_d     = idx_q;
        res_cnt_d = res_cnt_q;
        pend_w_d  = rd_w & ~abort_cmd;
        pend_x_d  = rd_x & ~abort_cmd;
        if (wb_req && !wb_we_i) begin
            case (reg_sel)
                2'd0:    dat_d = {29'd0, 1'b0, irq_en_q, 1'b0};
                2'd1:    dat_d = cfg_q;
                2'd2:    dat_d = {21'd0, state_q, 5'd0, aborted_q, done_q, busy};
                default: dat_d = cycles_rd;
            endcase
        end
        if (wb_wr && reg_sel == 2'd0) irq_en_d = wb_dat_i[1];
        if (wb_wr && reg_sel == 2'd1 && !busy) cfg_d = wb_dat_i;
        if (wb_wr && reg_sel == 2'd2) begin
            if (wb_dat_i[1]) done_d = 1'b0;
            if (wb_dat_i[2]) aborted_d = 1'b0;
        end
        if (rd_w || rd_x) idx_d = idx_q + 9'd1;
        if (state_q == S_LOAD_W && idx_q == N_W) idx_d = '0;
        if (res_wr) res_cnt_d = res_cnt_q + 8'd1;
        if (abort_cmd) aborted_d = 1'b1;
        if (state_q == S_DONE) done_d = 1'b1;
        if (start_cmd) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
            idx_d     = '0;
            res_cnt_d = '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_en_q  <= 1'b0;
            cfg_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            idx_q     <= '0;
            res_cnt_q <= '0;
            pend_w_q  <= 1'b0;
            pend_x_q  <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_en_q  <= irq_en_d;
            cfg_q     <= cfg_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            idx_q     <= idx_d;
            res_cnt_q <= res_cnt_d;
            pend_w_q  <= pend_w_d;
            pend_x_q  <= pend_x_d;
        end
    end

`ifdef NPU_SEQ_CYCLE_CNT_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (busy && cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        if (start_cmd) cycles_d = '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) cycles_q <= '0;
        else             cycles_q <= cycles_d;
    end

    assign cycles_rd = cycles_q;
`else
    assign cycles_rd = '0;
`endif
endmodule
